// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS instruction-memory boot loader.
// Holds the loader state encoding and word/byte geometry.
package mips_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_ERR,
    S_RUN
  } state_e;

  function automatic logic is_load(state_e s);
    return s inside {S_HDR, S_DATA, S_CSUM};
  endfunction

endpackage

// File: rtl/mips_imem_loader_asm.sv
// Byte-to-word assembler: big-endian shift register, byte index, and a
// word_done pulse in the cycle after the fourth byte of a word is accepted.
module loader_word_asm
  import mips_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              done_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    if (acc_i) begin
      word_d = {word_q[WORD_W-9:0], byte_i};
      idx_d  = idx_q + IDX_W'(1);
      done_d = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  assign word_o = word_q;
  assign done_o = done_q;

endmodule

// File: rtl/mips_imem_loader.sv
// Boot loader that streams a program into instruction memory, then releases
// the core. Define LOADER_CHECKSUM_EN to require a trailing data checksum.
module mips_imem_loader
  import mips_loader_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              pc_load,
  output logic [31:0]       pc_value,
  output logic              core_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = S_CSUM;
`else
  localparam state_e AFTER_DATA = S_RUN;
`endif

  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] tgt_q, tgt_d;
  logic            ready_q, pcl_q, pcl_d;
  logic            we;
  logic [31:0]     word;
  logic            done;
  logic            n_ovf;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     csum_q, csum_d;
`endif

  loader_word_asm u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc_i  (in_valid && ready_q),
    .byte_i (in_data),
    .word_o (word),
    .done_o (done)
  );

  assign n_ovf = (word > 32'(CAP));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    we      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE: if (start) state_d = S_HDR;
      S_HDR: if (done) begin
        if (n_ovf) begin
          state_d = S_ERR;
        end else if (word == 32'd0) begin
          state_d = AFTER_DATA;
        end else begin
          tgt_d   = word[ADDR_W:0];
          state_d = S_DATA;
        end
      end
      S_DATA: if (done) begin
        we    = 1'b1;
        cnt_d = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        csum_d = csum_q + word;
`endif
        if (cnt_d == tgt_q) state_d = AFTER_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (done) begin
        state_d = (word == csum_q) ? S_RUN : S_ERR;
      end
`endif
      default: ;
    endcase
  end

  // pc_load fires only on the transition into RUN
  assign pcl_d = (state_d == S_RUN) && (state_q != S_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      ready_q <= 1'b0;
      pcl_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      ready_q <= is_load(state_d);
      pcl_q   <= pcl_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign in_ready     = ready_q;
  assign imem_we      = we;
  assign imem_addr    = cnt_q[ADDR_W-1:0];
  assign imem_wdata   = word;
  assign pc_load      = pcl_q;
  assign pc_value     = RESET_PC;
  assign core_run     = (state_q == S_RUN);
  assign busy         = is_load(state_q);
  assign error        = (state_q == S_ERR);
  assign words_loaded = cnt_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Bench for mips_imem_loader: two instances (ADDR_W=10 and ADDR_W=2) share
// one byte stream and are checked against a stream-level reference model.
module tb_mips_imem_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  always #5 clk = ~clk;

  logic        a_rdy, a_we, a_pcl, a_run, a_busy, a_err;
  logic [9:0]  a_addr;
  logic [31:0] a_wd, a_pcv;
  logic [10:0] a_wl;

  logic        b_rdy, b_we, b_pcl, b_run, b_busy, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wd, b_pcv;
  logic [2:0]  b_wl;

  mips_imem_loader #(.ADDR_W(10), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_rdy),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wd),
    .pc_load(a_pcl), .pc_value(a_pcv), .core_run(a_run),
    .busy(a_busy), .error(a_err), .words_loaded(a_wl)
  );

  mips_imem_loader #(.ADDR_W(2), .RESET_PC(32'h0040_0000)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_rdy),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wd),
    .pc_load(b_pcl), .pc_value(b_pcv), .core_run(b_run),
    .busy(b_busy), .error(b_err), .words_loaded(b_wl)
  );

  int errors = 0;
  int checks = 0;
  int rdy_drop = 0;

  // Write/pc_load monitors; a write must follow a word-completing accept
  // and land at the next sequential address.
  wq_t         a_wq, b_wq;
  logic [31:0] a_mem [1024];
  int          a_pcn, b_pcn, a_terr, b_terr, a_bc, b_bc;
  bit          a_end, b_end;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_wq.delete(); a_pcn = 0; a_terr = 0; a_bc = 0; a_end = 0;
    end else begin
      if (a_we) begin
        a_wq.push_back(a_wd);
        a_mem[a_addr] = a_wd;
        if (!a_end || a_addr != 10'(a_wq.size() - 1)) a_terr++;
      end
      if (a_pcl) a_pcn++;
      a_end = in_valid && a_rdy && (a_bc == 3);
      if (in_valid && a_rdy) a_bc = (a_bc + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_wq.delete(); b_pcn = 0; b_terr = 0; b_bc = 0; b_end = 0;
    end else begin
      if (b_we) begin
        b_wq.push_back(b_wd);
        if (!b_end || b_addr != 2'(b_wq.size() - 1)) b_terr++;
      end
      if (b_pcl) b_pcn++;
      b_end = in_valid && b_rdy && (b_bc == 3);
      if (in_valid && b_rdy) b_bc = (b_bc + 1) % 4;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input bq_t s, input int gap, input bit chk);
    foreach (s[i]) begin
      in_valid = 1'b1; in_data = s[i];
      @(negedge clk);
      if (chk && a_rdy !== 1'b1) rdy_drop++;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        if (chk && i != s.size() - 1 && a_rdy !== 1'b1) rdy_drop++;
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic bq_t pack(input wq_t w);
    bq_t s;
    foreach (w[i]) for (int k = 3; k >= 0; k--) s.push_back(w[i][8*k +: 8]);
    return s;
  endfunction

  // Header word, n random data words, then the checksum word if enabled.
  function automatic wq_t build(input int unsigned n);
    wq_t w;
    logic [31:0] sum = 32'd0, x;
    w.push_back(n);
    if (n <= 1024) begin
      for (int i = 0; i < int'(n); i++) begin
        x = $urandom; w.push_back(x); sum += x;
      end
`ifdef LOADER_CHECKSUM_EN
      w.push_back(sum);
`endif
    end
    return w;
  endfunction

  // Reference: from a byte stream and capacity, the words that get written
  // and whether the core is released.
  task automatic model(input bq_t s, input int cap, output wq_t w, output bit run);
    logic [31:0] n, sum, x;
    w = {}; sum = 32'd0; run = 1'b0;
    n = {s[0], s[1], s[2], s[3]};
    if (n > 32'(cap)) return;
    for (int i = 0; i < int'(n); i++) begin
      x = {s[4+4*i], s[5+4*i], s[6+4*i], s[7+4*i]};
      w.push_back(x); sum += x;
    end
`ifdef LOADER_CHECKSUM_EN
    x = {s[4+4*n], s[5+4*n], s[6+4*n], s[7+4*n]};
    run = (x == sum);
`else
    run = 1'b1;
`endif
  endtask

  task automatic test_reset();
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", a_rdy); end
    checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL rst_imem_we got %b want 0", a_we); end
    checks++; if (a_addr !== 10'd0) begin errors++; $display("FAIL rst_addr got %h want 0", a_addr); end
    checks++; if (a_wd !== 32'd0) begin errors++; $display("FAIL rst_wdata got %h want 0", a_wd); end
    checks++; if (a_pcl !== 1'b0) begin errors++; $display("FAIL rst_pc_load got %b want 0", a_pcl); end
    checks++; if (a_run !== 1'b0) begin errors++; $display("FAIL rst_core_run got %b want 0", a_run); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", a_busy); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", a_err); end
    checks++; if (a_wl !== 11'd0) begin errors++; $display("FAIL rst_words got %0d want 0", a_wl); end
  endtask

  task automatic test_basic();
    wq_t w = '{32'd2, 32'hAC05_0001, 32'h8C07_0001};
`ifdef LOADER_CHECKSUM_EN
    w.push_back(32'h380C_0002);
`endif
    do_reset(); pulse_start(); send(pack(w), 0, 1'b0); idle(4);
    checks++; if (a_wq.size() != 2) begin errors++; $display("FAIL basic_nwr got %0d want 2", a_wq.size()); end
    checks++; if (a_mem[0] !== 32'hAC05_0001) begin errors++; $display("FAIL basic_w0 got %h want ac050001", a_mem[0]); end
    checks++; if (a_mem[1] !== 32'h8C07_0001) begin errors++; $display("FAIL basic_w1 got %h want 8c070001", a_mem[1]); end
    checks++; if (a_terr != 0) begin errors++; $display("FAIL basic_latency got %0d want 0", a_terr); end
    checks++; if (a_pcn != 1) begin errors++; $display("FAIL basic_pc_load got %0d want 1", a_pcn); end
    checks++; if (a_pcv !== 32'd0) begin errors++; $display("FAIL basic_pc_value got %h want 0", a_pcv); end
    checks++; if (b_pcv !== 32'h0040_0000) begin errors++; $display("FAIL basic_pc_value2 got %h want 00400000", b_pcv); end
    checks++; if (a_run !== 1'b1) begin errors++; $display("FAIL basic_core_run got %b want 1", a_run); end
    checks++; if (a_wl !== 11'd2) begin errors++; $display("FAIL basic_words got %0d want 2", a_wl); end
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL basic_ready_run got %b want 0", a_rdy); end
  endtask

  task automatic test_throttled();
    wq_t w = '{32'd2, 32'hAC05_0001, 32'h8C07_0001};
`ifdef LOADER_CHECKSUM_EN
    w.push_back(32'h380C_0002);
`endif
    rdy_drop = 0;
    do_reset(); pulse_start(); send(pack(w), 3, 1'b1); idle(4);
    checks++; if (a_wq.size() != 2) begin errors++; $display("FAIL thr_nwr got %0d want 2", a_wq.size()); end
    checks++; if (a_mem[0] !== 32'hAC05_0001 || a_mem[1] !== 32'h8C07_0001)
      begin errors++; $display("FAIL thr_words got %h %h want ac050001 8c070001", a_mem[0], a_mem[1]); end
    checks++; if (rdy_drop != 0) begin errors++; $display("FAIL thr_ready got %0d drops want 0", rdy_drop); end
    checks++; if (a_terr != 0) begin errors++; $display("FAIL thr_latency got %0d want 0", a_terr); end
    checks++; if (a_pcn != 1) begin errors++; $display("FAIL thr_pc_load got %0d want 1", a_pcn); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0 = $urandom, wn = $urandom;
    bq_t s = pack('{32'd2, w0, 32'hDEAD_BEEF});
    bq_t s2;
    wq_t w2 = '{32'd1, wn};
`ifdef LOADER_CHECKSUM_EN
    w2.push_back(wn);
`endif
    s2 = pack(w2);
    do_reset(); pulse_start();
    s = s[0:9];
    send(s, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (a_mem[0] !== w0) begin errors++; $display("FAIL mid_w0 got %h want %h", a_mem[0], w0); end
    @(negedge clk);
    checks++; if ({a_rdy, a_we, a_pcl, a_run, a_busy, a_err} !== 6'b0)
      begin errors++; $display("FAIL mid_flags got %b want 000000", {a_rdy, a_we, a_pcl, a_run, a_busy, a_err}); end
    checks++; if (a_addr !== 10'd0 || a_wd !== 32'd0 || a_wl !== 11'd0)
      begin errors++; $display("FAIL mid_regs got %h %h %0d want 0 0 0", a_addr, a_wd, a_wl); end
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_start(); send(s2, 1, 1'b0); idle(4);
    checks++; if (a_mem[0] !== wn) begin errors++; $display("FAIL mid_overwrite got %h want %h", a_mem[0], wn); end
    checks++; if (a_wl !== 11'd1) begin errors++; $display("FAIL mid_words got %0d want 1", a_wl); end
    checks++; if (a_run !== 1'b1) begin errors++; $display("FAIL mid_run got %b want 1", a_run); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int c = 0; c < 2; c++) begin
      do_reset(); pulse_start();
      send(pack('{32'd2, 32'h1, 32'hFFFF_FFFF, 32'(c)}), 0, 1'b0); idle(4);
      checks++; if (a_run !== (c == 0)) begin errors++; $display("FAIL csum%0d_run got %b want %b", c, a_run, c == 0); end
      checks++; if (a_err !== (c == 1)) begin errors++; $display("FAIL csum%0d_err got %b want %b", c, a_err, c == 1); end
      checks++; if (a_pcn != (c == 0 ? 1 : 0)) begin errors++; $display("FAIL csum%0d_pc_load got %0d want %0d", c, a_pcn, c == 0); end
    end
  endtask
`endif

  task automatic test_start_ignored();
    wq_t w = build(1);
    do_reset(); pulse_start(); send(pack(w), 0, 1'b0); idle(3);
    pulse_start(); idle(4);
    checks++; if (a_pcn != 1) begin errors++; $display("FAIL ign_run_pc_load got %0d want 1", a_pcn); end
    checks++; if (a_run !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL ign_run_state got %b%b want 10", a_run, a_busy); end
    do_reset(); pulse_start(); send(pack('{32'd1025}), 0, 1'b0); idle(3);
    pulse_start(); idle(4);
    checks++; if (a_err !== 1'b1 || a_busy !== 1'b0 || a_run !== 1'b0)
      begin errors++; $display("FAIL ign_err_state got %b%b%b want 100", a_err, a_busy, a_run); end
    @(posedge clk); #1 rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b0;
    idle(3);
    checks++; if (a_busy !== 1'b0 || a_rdy !== 1'b0 || a_err !== 1'b0)
      begin errors++; $display("FAIL ign_rst_start got %b%b%b want 000", a_busy, a_rdy, a_err); end
  endtask

  task automatic test_counts_random();
    int unsigned ns[$] = '{0, 4, 5, 1024, 1025};
    for (int i = 0; i < 12; i++) ns.push_back($urandom_range(6, 1));
    foreach (ns[c]) begin
      bq_t s = pack(build(ns[c]));
      wq_t ea, eb;
      bit  ra, rb;
      int  bad;
      model(s, 1024, ea, ra);
      model(s, 4, eb, rb);
      do_reset(); pulse_start();
      send(s, (c < 5) ? 0 : $urandom_range(2, 0), 1'b0);
      idle(4);
      checks++; if (a_wq.size() != ea.size()) begin errors++; $display("FAIL n%0d_a_nwr got %0d want %0d", ns[c], a_wq.size(), ea.size()); end
      bad = 0; foreach (ea[i]) if (i < a_wq.size() && a_wq[i] !== ea[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL n%0d_a_data got %0d bad want 0", ns[c], bad); end
      checks++; if (a_run !== ra || a_err !== !ra) begin errors++; $display("FAIL n%0d_a_state got run=%b err=%b want run=%b", ns[c], a_run, a_err, ra); end
      checks++; if (a_pcn != int'(ra)) begin errors++; $display("FAIL n%0d_a_pc_load got %0d want %0d", ns[c], a_pcn, ra); end
      checks++; if (a_wl !== 11'(ea.size())) begin errors++; $display("FAIL n%0d_a_words got %0d want %0d", ns[c], a_wl, ea.size()); end
      checks++; if (a_terr != 0) begin errors++; $display("FAIL n%0d_a_timing got %0d want 0", ns[c], a_terr); end
      checks++; if (b_wq.size() != eb.size()) begin errors++; $display("FAIL n%0d_b_nwr got %0d want %0d", ns[c], b_wq.size(), eb.size()); end
      bad = 0; foreach (eb[i]) if (i < b_wq.size() && b_wq[i] !== eb[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL n%0d_b_data got %0d bad want 0", ns[c], bad); end
      checks++; if (b_run !== rb || b_err !== !rb) begin errors++; $display("FAIL n%0d_b_state got run=%b err=%b want run=%b", ns[c], b_run, b_err, rb); end
      checks++; if (b_pcn != int'(rb)) begin errors++; $display("FAIL n%0d_b_pc_load got %0d want %0d", ns[c], b_pcn, rb); end
      checks++; if (b_wl !== 3'(eb.size())) begin errors++; $display("FAIL n%0d_b_words got %0d want %0d", ns[c], b_wl, eb.size()); end
      checks++; if (b_terr != 0) begin errors++; $display("FAIL n%0d_b_timing got %0d want 0", ns[c], b_terr); end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_throttled();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_start_ignored();
    test_counts_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
